fetch_unit: RTL

//  Instruction fetch and operand-address front end for the 6502 core; the producer side of the decoder handshake.
//  - Reads the opcode at PC and the 0-2 operand bytes its addressing mode needs, then resolves the effective address.
//  - Presents instruction/addr to the decoder with instruction_ready; holds them until the decoder returns instruction_done.
//  - Sits between the memory port and the decoder.

---
 rtl/fetch_pkg.sv | 51 +++++
 rtl/fetch_len_decode.sv | 56 +++++
 rtl/fetch_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the 6502 instruction fetch front end:
// FSM states, addressing modes, opcode overrides and a zero-page helper.
package fetch_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;

  typedef enum logic [3:0] {
    FETCH_OP,
    WAIT_OP,
    FETCH_LO,
    WAIT_LO,
    FETCH_HI,
    WAIT_HI,
    PTR_LO,
    WAIT_PLO,
    PTR_HI,
    WAIT_PHI,
    ISSUE,
    WAIT_DONE
  } state_e;

  typedef enum logic [3:0] {
    M_IMP,
    M_IMM,
    M_ZPG,
    M_ZPX,
    M_ZPY,
    M_ABS,
    M_ABX,
    M_ABY,
    M_IZX,
    M_IZY,
    M_REL
  } mode_e;

  localparam logic [DATA_W-1:0] OP_BRK    = 8'h00;
  localparam logic [DATA_W-1:0] OP_JSR    = 8'h20;
  localparam logic [DATA_W-1:0] OP_RTI    = 8'h40;
  localparam logic [DATA_W-1:0] OP_RTS    = 8'h60;
  localparam logic [DATA_W-1:0] OP_STX_ZY = 8'h96;
  localparam logic [DATA_W-1:0] OP_LDX_ZY = 8'hB6;
  localparam logic [DATA_W-1:0] OP_LDX_AY = 8'hBE;

  function automatic logic [ADDR_W-1:0] zp(
    input logic [DATA_W-1:0] b
  );
    return {{(ADDR_W-DATA_W){1'b0}}, b};
  endfunction

endpackage

// File: rtl/fetch_len_decode.sv
// Opcode -> addressing mode and instruction length (1-3 bytes).
// Pure combinational so a disassembler or trace unit can reuse it.
module fetch_len_decode
  import fetch_pkg::*;
(
  input  logic [DATA_W-1:0] i_op,
  output mode_e             o_mode,
  output logic [1:0]        o_len
);

  logic [2:0] w_bbb;
  logic [1:0] w_cc;

  assign w_bbb = i_op[4:2];
  assign w_cc  = i_op[1:0];

  always_comb begin
    o_mode = M_IMP;
    o_len  = 2'd1;
    if (w_cc == 2'b01) begin
      case (w_bbb)
        3'd0: o_mode = M_IZX;
        3'd1: o_mode = M_ZPG;
        3'd2: o_mode = M_IMM;
        3'd3: o_mode = M_ABS;
        3'd4: o_mode = M_IZY;
        3'd5: o_mode = M_ZPX;
        3'd6: o_mode = M_ABY;
        default: o_mode = M_ABX;
      endcase
    end else if (w_cc != 2'b11) begin
      case (w_bbb)
        3'd0: o_mode = M_IMM;
        3'd1: o_mode = M_ZPG;
        3'd3: o_mode = M_ABS;
        3'd4: o_mode = (w_cc == 2'b00) ? M_REL : M_IMP;
        3'd5: o_mode = M_ZPX;
        3'd7: o_mode = M_ABX;
        default: o_mode = M_IMP;
      endcase
    end
    case (i_op)
      OP_BRK, OP_RTI, OP_RTS: o_mode = M_IMP;
      OP_JSR:                 o_mode = M_ABS;
      OP_STX_ZY, OP_LDX_ZY:   o_mode = M_ZPY;
      OP_LDX_AY:              o_mode = M_ABY;
      default: ;
    endcase
    unique case (1'b1)
      (o_mode == M_IMP): o_len = 2'd1;
      (o_mode inside {M_ABS, M_ABX, M_ABY}): o_len = 2'd3;
      default: o_len = 2'd2;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// 6502 instruction fetch / effective-address front end feeding the decoder.
// Define FETCH_INDIRECT_EN to resolve (zp,X) and (zp),Y through pointer reads.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                REG_WIDTH  = DATA_W,
  parameter int                ADDR_WIDTH = ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = 16'h8000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [REG_WIDTH-1:0]  mem_data,
  input  logic                  mem_valid,
  input  logic [REG_WIDTH-1:0]  x_in,
  input  logic [REG_WIDTH-1:0]  y_in,
  output logic [REG_WIDTH-1:0]  instruction,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [REG_WIDTH-1:0]  operand,
  output logic                  instruction_ready,
  input  logic                  instruction_done,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_val,
  output logic [ADDR_WIDTH-1:0] pc
);

`ifdef FETCH_INDIRECT_EN
  localparam bit IND_EN = 1'b1;
`else
  localparam bit IND_EN = 1'b0;
`endif

  state_e                r_state;
  mode_e                 r_mode;
  logic [1:0]            r_len;
  logic [REG_WIDTH-1:0]  r_op;
  logic [REG_WIDTH-1:0]  r_lo;
  logic [REG_WIDTH-1:0]  r_hi;
  logic [REG_WIDTH-1:0]  r_plo;
  logic [ADDR_WIDTH-1:0] r_opnd_pc;
  logic                  r_armed;

  mode_e                 w_mode;
  logic [1:0]            w_len;
  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic [ADDR_WIDTH-1:0] w_abs;
  logic [REG_WIDTH-1:0]  w_zpx;
  logic [REG_WIDTH-1:0]  w_zpy;
  logic [REG_WIDTH-1:0]  w_ptr;
  logic [REG_WIDTH-1:0]  w_ptr_nx;
  logic [ADDR_WIDTH-1:0] w_ea;
  state_e                w_ops_next;

  fetch_len_decode u_dec (
    .i_op   (mem_data),
    .o_mode (w_mode),
    .o_len  (w_len)
  );

  assign w_pc_inc = pc + ADDR_WIDTH'(1);
  assign w_abs    = {r_hi, r_lo};
  assign w_zpx    = r_lo + x_in;
  assign w_zpy    = r_lo + y_in;
  assign w_ptr    = (r_mode == M_IZX) ? w_zpx : r_lo;
  assign w_ptr_nx = w_ptr + REG_WIDTH'(1);

  assign w_ops_next =
    (IND_EN && (r_mode == M_IZX || r_mode == M_IZY)) ?
    PTR_LO : ISSUE;

  always_comb begin
    w_ea = '0;
    case (r_mode)
      M_IMM, M_REL: w_ea = r_opnd_pc;
      M_ZPG: w_ea = zp(r_lo);
      M_ZPX: w_ea = zp(w_zpx);
      M_ZPY: w_ea = zp(w_zpy);
      M_ABS: w_ea = w_abs;
      M_ABX: w_ea = w_abs + zp(x_in);
      M_ABY: w_ea = w_abs + zp(y_in);
      M_IZX: w_ea = IND_EN ? {r_hi, r_plo} : zp(w_zpx);
      M_IZY: w_ea = IND_EN ? {r_hi, r_plo} + zp(y_in) : zp(r_lo);
      default: w_ea = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state           <= FETCH_OP;
      r_mode            <= M_IMP;
      r_len             <= 2'd1;
      r_op              <= '0;
      r_lo              <= '0;
      r_hi              <= '0;
      r_plo             <= '0;
      r_opnd_pc         <= '0;
      r_armed           <= 1'b0;
      pc                <= RESET_PC;
      mem_addr          <= '0;
      mem_rd            <= 1'b0;
      instruction       <= '0;
      addr              <= '0;
      operand           <= '0;
      instruction_ready <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      case (r_state)
        FETCH_OP: begin
          mem_addr <= pc;
          mem_rd   <= 1'b1;
          r_state  <= WAIT_OP;
        end
        WAIT_OP: if (mem_valid) begin
          r_op      <= mem_data;
          r_mode    <= w_mode;
          r_len     <= w_len;
          r_lo      <= '0;
          r_hi      <= '0;
          r_opnd_pc <= w_pc_inc;
          pc        <= w_pc_inc;
          r_state   <= (w_len == 2'd1) ? ISSUE : FETCH_LO;
        end
        FETCH_LO: begin
          mem_addr <= pc;
          mem_rd   <= 1'b1;
          r_state  <= WAIT_LO;
        end
        WAIT_LO: if (mem_valid) begin
          r_lo    <= mem_data;
          pc      <= w_pc_inc;
          r_state <= (r_len == 2'd3) ? FETCH_HI : w_ops_next;
        end
        FETCH_HI: begin
          mem_addr <= pc;
          mem_rd   <= 1'b1;
          r_state  <= WAIT_HI;
        end
        WAIT_HI: if (mem_valid) begin
          r_hi    <= mem_data;
          pc      <= w_pc_inc;
          r_state <= w_ops_next;
        end
        // pointer reads stay in page zero and leave pc alone
        PTR_LO: begin
          mem_addr <= zp(w_ptr);
          mem_rd   <= 1'b1;
          r_state  <= WAIT_PLO;
        end
        WAIT_PLO: if (mem_valid) begin
          r_plo   <= mem_data;
          r_state <= PTR_HI;
        end
        PTR_HI: begin
          mem_addr <= zp(w_ptr_nx);
          mem_rd   <= 1'b1;
          r_state  <= WAIT_PHI;
        end
        WAIT_PHI: if (mem_valid) begin
          r_hi    <= mem_data;
          r_state <= ISSUE;
        end
        ISSUE: begin
          instruction       <= r_op;
          addr              <= w_ea;
          operand           <= r_lo;
          instruction_ready <= 1'b1;
          r_armed           <= 1'b0;
          r_state           <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!r_armed) begin
            r_armed <= 1'b1;
          end else if (instruction_done) begin
            instruction_ready <= 1'b0;
            r_state           <= FETCH_OP;
            if (pc_load) pc <= pc_load_val;
          end
        end
        default: r_state <= FETCH_OP;
      endcase
    end
  end

endmodule
